// File: rtl/program_loader_if.sv
// Program-memory write port driven by the serial boot loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_value;
    logic                  we;

    modport master (output write_addr, write_value, we);
    modport slave  (input  write_addr, write_value, we);
endinterface

// File: rtl/program_loader.sv
// UART (8N1) boot loader: a 16-bit little-endian length, then that many bytes packed
// little-endian into program-memory words; the core is held in reset until the image is in.
module program_loader #(
    parameter int WORD_MAG           = 5,
    parameter int PROGRAM_ADDR_WIDTH = 5,
    parameter int CLKS_PER_BIT       = 868
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             uart_rx,
    program_loader_if.master pmem,
    output logic             core_reset,
    output logic             load_done,
    output logic             load_error
);
    localparam int WORD_WIDTH   = 1 << WORD_MAG;
    localparam int WORD_BYTES   = WORD_WIDTH / 8;
    localparam int PROGRAM_SIZE = 1 << PROGRAM_ADDR_WIDTH;
    localparam int WADDR_WIDTH  = PROGRAM_ADDR_WIDTH - (WORD_MAG - 3);
    localparam int LANE_WIDTH   = (WORD_MAG > 3) ? WORD_MAG - 3 : 1;
    localparam int CNT_WIDTH    = $clog2(CLKS_PER_BIT);
    localparam int REM_WIDTH    = PROGRAM_ADDR_WIDTH + 1;

    localparam logic [CNT_WIDTH-1:0]  HALF_BIT_LAST = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_WIDTH-1:0]  FULL_BIT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [LANE_WIDTH-1:0] LAST_LANE     = LANE_WIDTH'(WORD_BYTES - 1);
    localparam logic [REM_WIDTH-1:0]  REM_ONE       = REM_WIDTH'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERROR} ld_state_t;

    logic r_rx_meta;
    logic r_rx_sync;

    rx_state_t            r_rx_state,   w_rx_state_nxt;
    logic [CNT_WIDTH-1:0] r_clk_cnt,    w_clk_cnt_nxt;
    logic [2:0]           r_bit_idx,    w_bit_idx_nxt;
    logic [7:0]           r_shift,      w_shift_nxt;
    logic                 r_byte_valid, w_byte_valid_nxt;
    logic                 r_frame_err,  w_frame_err_nxt;

    ld_state_t             r_ld_state,  w_ld_state_nxt;
    logic [7:0]            r_len_lo,    w_len_lo_nxt;
    logic [REM_WIDTH-1:0]  r_remaining, w_remaining_nxt;
    logic [LANE_WIDTH-1:0] r_byte_idx,  w_byte_idx_nxt;
    logic [WORD_WIDTH-1:0] r_word,      w_word_nxt;
    logic [WADDR_WIDTH-1:0] r_addr,     w_addr_nxt;
    logic                  r_we,        w_we_nxt;
    logic [15:0]           w_length;

    // Reset to 1 so the synchroniser never presents a false start bit after reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_clk_cnt_nxt    = r_clk_cnt + CNT_WIDTH'(1);
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_clk_cnt_nxt = '0;
                if (!r_rx_sync) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_clk_cnt == HALF_BIT_LAST) begin
                    w_clk_cnt_nxt  = '0;
                    w_bit_idx_nxt  = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_clk_cnt == FULL_BIT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == FULL_BIT_LAST) begin
                    w_byte_valid_nxt = r_rx_sync;
                    w_frame_err_nxt  = !r_rx_sync;
                    w_rx_state_nxt   = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same old values.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_clk_cnt    <= w_clk_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    assign w_length = {r_shift, r_len_lo};

    // r_we marks the write cycle; the word, address and lane index advance as it ends.
    always_comb begin
        w_ld_state_nxt  = r_ld_state;
        w_len_lo_nxt    = r_len_lo;
        w_remaining_nxt = r_remaining;
        w_byte_idx_nxt  = r_byte_idx;
        w_word_nxt      = r_word;
        w_addr_nxt      = r_addr;
        w_we_nxt        = 1'b0;
        case (r_ld_state)
            LD_LEN_LO: begin
                if (r_frame_err) begin
                    w_ld_state_nxt = LD_ERROR;
                end else if (r_byte_valid) begin
                    w_len_lo_nxt   = r_shift;
                    w_ld_state_nxt = LD_LEN_HI;
                end
            end
            LD_LEN_HI: begin
                if (r_frame_err) begin
                    w_ld_state_nxt = LD_ERROR;
                end else if (r_byte_valid) begin
                    if ({16'd0, w_length} > 32'(PROGRAM_SIZE)) begin
                        w_ld_state_nxt = LD_ERROR;
                    end else if (w_length == 16'd0) begin
                        w_ld_state_nxt = LD_DONE;
                    end else begin
                        w_remaining_nxt = REM_WIDTH'(w_length);
                        w_byte_idx_nxt  = '0;
                        w_ld_state_nxt  = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (r_we) begin
                    w_addr_nxt     = r_addr + WADDR_WIDTH'(1);
                    w_word_nxt     = '0;
                    w_byte_idx_nxt = '0;
                    if (r_remaining == '0) w_ld_state_nxt = LD_DONE;
                end else if (r_frame_err) begin
                    w_ld_state_nxt = LD_ERROR;
                end else if (r_byte_valid) begin
                    w_word_nxt[8*int'(r_byte_idx) +: 8] = r_shift;
                    w_remaining_nxt = r_remaining - REM_ONE;
                    w_byte_idx_nxt  = r_byte_idx + LANE_WIDTH'(1);
                    w_we_nxt        = (r_byte_idx == LAST_LANE) || (r_remaining == REM_ONE);
                end
            end
            LD_DONE:  w_ld_state_nxt = LD_DONE;
            LD_ERROR: w_ld_state_nxt = LD_ERROR;
            default:  w_ld_state_nxt = LD_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_ld_state  <= LD_LEN_LO;
            r_len_lo    <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
        end else begin
            r_ld_state  <= w_ld_state_nxt;
            r_len_lo    <= w_len_lo_nxt;
            r_remaining <= w_remaining_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_word      <= w_word_nxt;
            r_addr      <= w_addr_nxt;
            r_we        <= w_we_nxt;
        end
    end

    assign pmem.write_addr  = r_addr;
    assign pmem.write_value = r_word;
    assign pmem.we          = r_we;
    assign core_reset       = (r_ld_state != LD_DONE);
    assign load_done        = (r_ld_state == LD_DONE);
    assign load_error       = (r_ld_state == LD_ERROR);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: UART frames in, program-memory writes and status out.
module tb_program_loader;
    localparam int CPB = 8;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;
    logic uart_rx = 1'b1;
    logic core_reset;
    logic load_done;
    logic load_error;

    program_loader_if #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) pmem ();

    program_loader #(
        .WORD_MAG          (5),
        .PROGRAM_ADDR_WIDTH(5),
        .CLKS_PER_BIT      (CPB)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .uart_rx   (uart_rx),
        .pmem      (pmem),
        .core_reset(core_reset),
        .load_done (load_done),
        .load_error(load_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc         = 0;
    int         last_wr_cyc = -1;
    int         done_cyc    = -1;
    logic       prev_done   = 1'b0;
    logic [2:0]  wr_addr_q[$];
    logic [31:0] wr_val_q[$];

    // Write/status monitor sampled on the falling edge, cleared while reset is held.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset_b) begin
            wr_addr_q.delete();
            wr_val_q.delete();
            last_wr_cyc = -1;
            done_cyc    = -1;
            prev_done   = 1'b0;
        end else begin
            if (pmem.we) begin
                wr_addr_q.push_back(pmem.write_addr);
                wr_val_q.push_back(pmem.write_value);
                last_wr_cyc = cyc;
            end
            if (load_done && !prev_done) done_cyc = cyc;
            prev_done = load_done;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_val(input int i);
        return (i < wr_val_q.size()) ? wr_val_q[i] : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] wr_addr(input int i);
        return (i < wr_addr_q.size()) ? {29'd0, wr_addr_q[i]} : 32'hxxxx_xxxx;
    endfunction

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        uart_rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_b = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        idle_bits(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_reset"}, {31'd0, core_reset}, 32'd1);
        check({tag, "_we"},         {31'd0, pmem.we},    32'd0);
        check({tag, "_addr"},       {29'd0, pmem.write_addr}, 32'd0);
        check({tag, "_value"},      pmem.write_value,    32'd0);
        check({tag, "_done"},       {31'd0, load_done},  32'd0);
        check({tag, "_error"},      {31'd0, load_error}, 32'd0);
    endtask

    initial begin
        // Reset state.
        do_reset();
        check_reset_outputs("rst");

        // Length 4: one full word.
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        idle_bits(3);
        check("len4_writes", wr_val_q.size(), 32'd1);
        check("len4_addr0", wr_addr(0), 32'd0);
        check("len4_val0", wr_val(0), 32'h4433_2211);
        check("len4_done", {31'd0, load_done}, 32'd1);
        check("len4_core_reset", {31'd0, core_reset}, 32'd0);
        check("len4_done_latency", done_cyc - last_wr_cyc, 32'd1);

        // Length 6: full word then a zero-padded partial word.
        do_reset();
        send_byte(8'h06, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
        send_byte(8'hEE, 1'b1); send_byte(8'hFF, 1'b1);
        idle_bits(3);
        check("len6_writes", wr_val_q.size(), 32'd2);
        check("len6_addr0", wr_addr(0), 32'd0);
        check("len6_val0", wr_val(0), 32'hDDCC_BBAA);
        check("len6_addr1", wr_addr(1), 32'd1);
        check("len6_val1", wr_val(1), 32'h0000_FFEE);
        check("len6_done", {31'd0, load_done}, 32'd1);
        check("len6_done_latency", done_cyc - last_wr_cyc, 32'd1);

        // Length 0: done immediately, later bytes ignored.
        do_reset();
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        idle_bits(2);
        check("len0_done", {31'd0, load_done}, 32'd1);
        check("len0_core_reset", {31'd0, core_reset}, 32'd0);
        send_byte(8'h55, 1'b1);
        idle_bits(3);
        check("len0_writes", wr_val_q.size(), 32'd0);
        check("len0_still_done", {31'd0, load_done}, 32'd1);

        // Length 33 exceeds a 32-byte program memory.
        do_reset();
        send_byte(8'h21, 1'b1); send_byte(8'h00, 1'b1);
        idle_bits(2);
        check("over_error", {31'd0, load_error}, 32'd1);
        check("over_core_reset", {31'd0, core_reset}, 32'd1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        idle_bits(3);
        check("over_writes", wr_val_q.size(), 32'd0);
        check("over_still_error", {31'd0, load_error}, 32'd1);
        check("over_done", {31'd0, load_done}, 32'd0);

        // Framing error on the first data byte.
        do_reset();
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b0);
        idle_bits(2);
        send_byte(8'h22, 1'b1);
        idle_bits(3);
        check("ferr_error", {31'd0, load_error}, 32'd1);
        check("ferr_writes", wr_val_q.size(), 32'd0);
        check("ferr_core_reset", {31'd0, core_reset}, 32'd1);

        // Asynchronous reset in the middle of a frame, then a clean load.
        send_bit(1'b0);
        send_bit(1'b1);
        #2 reset_b = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        idle_bits(2);
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hA1, 1'b1); send_byte(8'hB2, 1'b1);
        send_byte(8'hC3, 1'b1); send_byte(8'hD4, 1'b1);
        idle_bits(3);
        check("reload_writes", wr_val_q.size(), 32'd1);
        check("reload_val0", wr_val(0), 32'hD4C3_B2A1);
        check("reload_done", {31'd0, load_done}, 32'd1);

        // Two-cycle low glitch must not be taken as a start bit.
        do_reset();
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        idle_bits(4);
        check("glitch_writes", wr_val_q.size(), 32'd0);
        check("glitch_error", {31'd0, load_error}, 32'd0);
        check("glitch_done", {31'd0, load_done}, 32'd0);
        send_byte(8'h04, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
        idle_bits(3);
        check("glitch_load_writes", wr_val_q.size(), 32'd1);
        check("glitch_load_addr0", wr_addr(0), 32'd0);
        check("glitch_load_val0", wr_val(0), 32'h0403_0201);
        check("glitch_load_done", {31'd0, load_done}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Serial boot loader that fills the core's program memory before the core runs.
- Receives an 8N1 UART byte stream and assembles bytes into little-endian words.
- Drives the program-memory write port (write_addr / write_value / we) and holds the core in reset until the image is complete.
- Sits upstream of the core and program memory in the board top level: uart_rx pin in, program-memory write port and core reset out.

Parameters:
- WORD_MAG, 5: log2 of word width; WORD_WIDTH = 1<<WORD_MAG; WORD_BYTES = WORD_WIDTH/8.
- PROGRAM_ADDR_WIDTH, 5: byte address width of program memory; PROGRAM_SIZE = 1<<PROGRAM_ADDR_WIDTH bytes.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); must be >= 4.

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- uart_rx  in  1  asynchronous serial input, idle high
- pmem_write_addr  out  PROGRAM_ADDR_WIDTH-(WORD_MAG-3)  word address of the write
- pmem_write_value  out  WORD_WIDTH  assembled word; byte k at bits [8k+7:8k]
- pmem_we  out  1  one-cycle write strobe
- core_reset  out  1  high while loading or after an error; low once the load is done
- load_done  out  1  sticky, set when the image is fully written
- load_error  out  1  sticky, set on framing error or oversize length

Behaviour:
- Clock and reset: one clock, clk. reset_b is asynchronous and active-low; every flop clears immediately on reset_b=0.
- Reset values: core_reset=1, pmem_we=0, pmem_write_addr=0, pmem_write_value=0, load_done=0, load_error=0. Both FSMs reset to IDLE / LEN_LO.
- Input sync: uart_rx passes through a 2-flop synchroniser (reset value 1). All timing below refers to the synchronised signal.
- Receiver FSM:
  - IDLE: wait for synced rx = 0, then go to START.
  - START: count CLKS_PER_BIT/2 cycles and resample. If rx = 1, treat as a glitch and return to IDLE. If rx = 0, go to DATA.
  - DATA: sample 8 bits LSB first, one every CLKS_PER_BIT cycles, then go to STOP.
  - STOP: sample once after CLKS_PER_BIT cycles. If rx = 1, pulse byte_valid for 1 cycle with the byte. If rx = 0, pulse frame_err for 1 cycle. Return to IDLE.
- Loader FSM:
  - LEN_LO: first byte is length[7:0]; go to LEN_HI.
  - LEN_HI: second byte is length[15:8].
    - If length > PROGRAM_SIZE: go to ERROR.
    - If length = 0: go to DONE.
    - Otherwise: go to DATA.
  - DATA: each byte goes into byte lane byte_idx of the assembly word; remaining count decrements.
    - When byte_idx = WORD_BYTES-1, or remaining reaches 0: on the next cycle pmem_we=1 with the current address and word; the address increments after the write and the assembly register clears to 0.
    - If remaining reaches 0: go to DONE after that write cycle.
  - Partial final word: lanes that received no byte are written as 0.
  - DONE: load_done=1 and core_reset=0 from the cycle after the final write (or the cycle after LEN_HI when length = 0). Terminal; further rx bytes are ignored; only reset_b restarts a load.
  - ERROR: load_error=1, core_reset stays 1, no further writes. Terminal until reset_b.
- frame_err in any loader state other than DONE or ERROR: go to ERROR.
- Write/byte collision: a write and a byte arrival cannot coincide, because bytes are at least 10*CLKS_PER_BIT cycles apart; no arbitration is needed.
- Address wrap: cannot occur, because length <= PROGRAM_SIZE bounds the number of words.
- Reset mid-load: all outputs return to reset values immediately; partially written memory is not cleaned up.

Test Plan:
- Length 4 (04 00), then 11 22 33 44 -> one pmem_we, addr 0, value 0x44332211; core_reset falls the cycle after; load_done=1.
- Length 6, then AA BB CC DD EE FF -> addr 0 = 0xDDCCBBAA, addr 1 = 0x0000FFEE; exactly two strobes; then done.
- Length 0 (00 00) -> no pmem_we; load_done=1 and core_reset=0 the cycle after the second byte; a later byte 0x55 causes no write.
- Length 33 (21 00) with PROGRAM_SIZE=32 -> load_error=1, core_reset stays 1, zero writes; subsequent bytes ignored.
- Length 4; the third byte is sent with stop bit 0 -> load_error=1 with no write issued. Then pulse reset_b low mid-stream -> all outputs return to reset values asynchronously, and a fresh valid frame loads correctly.
- With CLKS_PER_BIT=8, a 2-cycle low glitch on uart_rx -> no byte received and the loader stays in LEN_LO; a following valid frame loads normally.
